// File: rtl/spart_rx.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// spart_rx -- 8N1 asynchronous serial receiver with a programmable bit period.
//
// A falling edge on the synchronised line starts a frame. The start bit is
// sampled half a bit period later, and the eight data bits (LSB first) and the
// stop bit are sampled one full bit period apart after that. A frame with a
// good stop bit updates rx_data and raises rda. A frame with a bad stop bit
// only raises frame_err.
//
// Ports
//   clk        system clock
//   rst        asynchronous active-low reset
//   rxd        serial line, idle high, asynchronous to clk
//   baud_div   clocks per bit (values below 4 act as 4), latched at frame start
//   clr_rda    one-cycle read acknowledge, clears rda and overrun
//   rx_data    last good received byte
//   rda        receive data available
//   frame_err  sticky: last frame had a stop bit of 0
//   overrun    sticky: good byte completed while rda was still set
//   busy       receiver is inside a frame
//   shift      one-cycle pulse in the clock that precedes each bit sample
// -----------------------------------------------------------------------------
module spart_rx #(
    parameter int unsigned DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rxd,
    input  logic [DIV_W-1:0] baud_div,
    input  logic             clr_rda,
    output logic [7:0]       rx_data,
    output logic             rda,
    output logic             frame_err,
    output logic             overrun,
    output logic             busy,
    output logic             shift
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_e;

    state_e           state_q, state_d;

    logic             sync1_q;
    logic             rxd_s_q;
    logic [1:0]       vld_q;
    logic             armed_q, armed_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       sh_q, sh_d;
    logic [7:0]       data_q, data_d;
    logic             rda_q, rda_d;
    logic             ferr_q, ferr_d;
    logic             ovr_q, ovr_d;

    logic [DIV_W-1:0] eff_div;
    logic             sample;
    logic             start_det;

    assign eff_div   = (baud_div < DIV_W'(4)) ? DIV_W'(4) : baud_div;
    assign sample    = (state_q != IDLE) && (cnt_q == '0);
    // armed_q only becomes set once the line has really been observed high,
    // so a line held low through reset is not mistaken for a start edge.
    assign start_det = (state_q == IDLE) && armed_q && !rxd_s_q;

    // Two-flop synchroniser. vld_q marks when rxd_s_q carries a real sample
    // rather than its reset value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= 1'b1;
            rxd_s_q <= 1'b1;
            vld_q   <= '0;
        end else begin
            sync1_q <= rxd;
            rxd_s_q <= sync1_q;
            vld_q   <= {vld_q[0], 1'b1};
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (start_det) state_d = START;
            START: if (sample) state_d = rxd_s_q ? IDLE : DATA;
            DATA:  if (sample && (bit_q == 3'd7)) state_d = STOP;
            STOP:  if (sample) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        busy  = (state_q != IDLE);
        shift = sample;
    end

    // Datapath next-state
    always_comb begin
        armed_d = armed_q;
        div_d   = div_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        sh_d    = sh_q;
        data_d  = data_q;
        rda_d   = rda_q;
        ferr_d  = ferr_q;
        ovr_d   = ovr_q;

        if (vld_q[1] && rxd_s_q) begin
            armed_d = 1'b1;
        end

        if (start_det) begin
            armed_d = 1'b0;
            div_d   = eff_div;
            cnt_d   = eff_div >> 1;
        end else if (state_q != IDLE) begin
            if (sample) begin
                cnt_d = div_q - DIV_W'(1);
            end else begin
                cnt_d = cnt_q - DIV_W'(1);
            end
        end

        if (sample && (state_q == START)) begin
            bit_d = '0;
        end

        if (sample && (state_q == DATA)) begin
            sh_d  = {rxd_s_q, sh_q[7:1]};
            bit_d = bit_q + 3'd1;
        end

        if (clr_rda) begin
            rda_d = 1'b0;
            ovr_d = 1'b0;
        end

        // A good byte wins over a coincident clr_rda for rda, while the
        // acknowledge still clears any overrun.
        if (sample && (state_q == STOP)) begin
            if (rxd_s_q) begin
                data_d = sh_q;
                rda_d  = 1'b1;
                ferr_d = 1'b0;
                ovr_d  = !clr_rda && (ovr_q || rda_q);
            end else begin
                ferr_d = 1'b1;
            end
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            armed_q <= 1'b0;
            div_q   <= '0;
            cnt_q   <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            data_q  <= '0;
            rda_q   <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            armed_q <= armed_d;
            div_q   <= div_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            data_q  <= data_d;
            rda_q   <= rda_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

    assign rx_data   = data_q;
    assign rda       = rda_q;
    assign frame_err = ferr_q;
    assign overrun   = ovr_q;

endmodule
